// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the tx/rx pair
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_CNT_BAUD_MAX      = 5207;
    localparam int UART_CNT_HALF_BAUD_MAX = UART_CNT_BAUD_MAX / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - enable-gated 0..CNT_MAX bit-time counter with bit_end tick
module uart_baud_cnt #(
    parameter int CNT_MAX = 5207,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt;

    assign bit_end = en && (cnt == MAX_V);

    // Held at zero while disabled so every enabled span starts a fresh bit time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-wide UART transmitter with optional parity and 1/2 stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int CNT_BAUD_MAX = UART_CNT_BAUD_MAX,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] pi_data,
    input  logic                   pi_flag,
    output logic                   pi_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;

    localparam logic PAR_ODD   = (PARITY_ODD != 0);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    logic [2:0]             state;
    logic [UART_DATA_W-1:0] shift;
    logic [2:0]             bit_idx;
    logic                   stop_cnt;
    logic                   parity;
    logic                   bit_end;

    assign pi_ready = (state == S_IDLE);
    assign busy     = !pi_ready;

    uart_baud_cnt #(
        .CNT_MAX(CNT_BAUD_MAX)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (state != S_IDLE),
        .bit_end(bit_end)
    );

    // tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state and stays a clean flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pi_flag) begin
                        shift    <= pi_data;
                        parity   <= uart_parity(pi_data, PAR_ODD);
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= S_START;
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state <= S_DATA;
                        tx    <= shift[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx    <= parity;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            state   <= S_IDLE;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx in 8N1, 8E1, 8O1 and 8N2
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pi_data;
    logic [3:0] pi_flag;
    logic [3:0] pi_ready;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CNT_BAUD_MAX(9), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag[0]),
        .pi_ready(pi_ready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.CNT_BAUD_MAX(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag[1]),
        .pi_ready(pi_ready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.CNT_BAUD_MAX(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag[2]),
        .pi_ready(pi_ready[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.CNT_BAUD_MAX(9), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag[3]),
        .pi_ready(pi_ready[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(tx_done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in handshake cycle N and returns in cycle N+F+1 (the tx_done cycle).
    task automatic frame(input int i, input logic [7:0] d, input int par_en, input logic par_bit,
                         input int stops, input bit hold, input logic [7:0] nd);
        int   f;
        int   b;
        logic exp;
        f = (10 + par_en + stops - 1) * 10;
        chk($sformatf("u%0d ready_at_handshake", i), pi_ready[i], 1);
        pi_data    = d;
        pi_flag[i] = 1'b1;
        tick();
        if (!hold) pi_flag[i] = 1'b0;
        for (int c = 1; c <= f; c++) begin
            if (c == 25) pi_data = hold ? nd : ~d;
            b = (c - 1) / 10;
            if (b == 0)                      exp = 1'b0;
            else if (b <= 8)                 exp = d[b-1];
            else if (b == 9 && par_en != 0)  exp = par_bit;
            else                             exp = 1'b1;
            chk($sformatf("u%0d tx d=%02h clk=%0d", i, d, c), tx[i], exp);
            chk($sformatf("u%0d ready_low d=%02h clk=%0d", i, d, c), pi_ready[i], 0);
            chk($sformatf("u%0d no_done d=%02h clk=%0d", i, d, c), tx_done[i], 0);
            if (c == 1) chk($sformatf("u%0d busy d=%02h", i, d), busy[i], 1);
            tick();
        end
        chk($sformatf("u%0d done_pulse d=%02h", i, d), tx_done[i], 1);
        chk($sformatf("u%0d ready_after d=%02h", i, d), pi_ready[i], 1);
        chk($sformatf("u%0d tx_idle d=%02h", i, d), tx[i], 1);
    endtask

    initial begin
        rst     = 1'b1;
        pi_flag = 4'b0000;
        pi_data = 8'h00;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d reset_tx", i), tx[i], 1);
            chk($sformatf("u%0d reset_ready", i), pi_ready[i], 1);
            chk($sformatf("u%0d reset_busy", i), busy[i], 0);
            chk($sformatf("u%0d reset_done", i), tx_done[i], 0);
        end
        rst = 1'b0;
        tick();

        frame(0, 8'h55, 0, 1'b0, 1, 1'b0, 8'h00);
        tick();
        chk("8n1 done_one_cycle", tx_done[0], 0);

        frame(1, 8'h07, 1, 1'b1, 1, 1'b0, 8'h00);
        tick();
        frame(1, 8'h03, 1, 1'b0, 1, 1'b0, 8'h00);
        tick();
        frame(2, 8'h07, 1, 1'b0, 1, 1'b0, 8'h00);
        tick();
        frame(3, 8'hFF, 0, 1'b0, 2, 1'b0, 8'h00);
        tick();
        chk("8n2 done_one_cycle", tx_done[3], 0);

        frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, 8'h3C);
        frame(0, 8'h3C, 0, 1'b0, 1, 1'b0, 8'h00);
        tick();
        chk("b2b idle_after", tx[0], 1);

        pi_data    = 8'hC3;
        pi_flag[0] = 1'b1;
        tick();
        pi_flag[0] = 1'b0;
        repeat (44) tick();
        chk("rst_mid bit3_low", tx[0], 0);
        rst = 1'b1;
        #1;
        chk("rst_mid tx_high", tx[0], 1);
        chk("rst_mid ready", pi_ready[0], 1);
        chk("rst_mid busy", busy[0], 0);
        chk("rst_mid done", tx_done[0], 0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk($sformatf("post_rst no_done %0d", c), tx_done[0], 0);
            chk($sformatf("post_rst ready %0d", c), pi_ready[0], 1);
            chk($sformatf("post_rst tx %0d", c), tx[0], 1);
        end
        frame(0, 8'h81, 0, 1'b0, 1, 1'b0, 8'h00);
        tick();
        chk("post_rst done_one_cycle", tx_done[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
